// File: rtl/fifo_wr_ptr_full_pkg.sv
// Shared async-FIFO helpers: pointer width, Gray conversions and the full-compare.
// Used by both the write-side full block and the read-side empty block.
package fifo_wr_ptr_full_pkg;

  // Working width of the helper functions; callers zero-extend in and truncate out.
  localparam int FN_W = 32;

  localparam int DEFAULT_ADDR_WIDTH = 3;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [FN_W-1:0] bin_to_gray(input logic [FN_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray_to_bin(input logic [FN_W-1:0] gray);
    logic [FN_W-1:0] bin;
    bin          = '0;
    bin[FN_W-1]  = gray[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  function automatic logic full_match(input logic [FN_W-1:0] w_gray,
                                      input logic [FN_W-1:0] r_gray,
                                      input int              addr_width);
    logic [FN_W-1:0] flip;
    flip = FN_W'(3) << (addr_width - 1);
    return w_gray == (r_gray ^ flip);
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_full.sv
// Async FIFO write-side pointer and full-flag controller (write clock domain).
// Define FIFO_WR_ALMOST_FULL_EN to add the AF_LEVEL parameter and the W_ALMOST_FULL flag.
module fifo_wr_ptr_full
  import fifo_wr_ptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL   = 6
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   R_PTR_SYNC,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic                  W_CLKEN,
  output logic [ADDR_WIDTH:0]   W_PTR,
`ifdef FIFO_WR_ALMOST_FULL_EN
  output logic                  W_FULL,
  output logic                  W_ALMOST_FULL
`else
  output logic                  W_FULL
`endif
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] gray_q, gray_d;
  logic             full_q, full_d;
  logic             accept;

  // Reset also gates the enable so the memory never sees a write while RST is low.
  always_comb begin
    accept = W_INC & ~full_q & RST;
    wbin_d = wbin_q + PTR_W'(accept);
    gray_d = PTR_W'(bin_to_gray(FN_W'(wbin_d)));
    full_d = full_match(FN_W'(gray_d), FN_W'(R_PTR_SYNC), ADDR_WIDTH);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbin_q <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      gray_q <= gray_d;
      full_q <= full_d;
    end
  end

  assign W_ADDR  = wbin_q[ADDR_WIDTH-1:0];
  assign W_CLKEN = accept;
  assign W_PTR   = gray_q;
  assign W_FULL  = full_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level;
  logic             af_q, af_d;

  // Fill level uses the post-write pointer so the flag lines up with W_FULL timing.
  always_comb begin
    rbin  = PTR_W'(gray_to_bin(FN_W'(R_PTR_SYNC)));
    level = wbin_d - rbin;
    af_d  = (level >= PTR_W'(AF_LEVEL));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign W_ALMOST_FULL = af_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Scoreboard bench for fifo_wr_ptr_full (ADDR_WIDTH=3, AF_LEVEL=6); the almost-full
// column is checked only when FIFO_WR_ALMOST_FULL_EN is defined.
module tb_fifo_wr_ptr_full;

  localparam int AW = 3;
  localparam int PW = AW + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          W_INC = 1'b0;
  logic [PW-1:0] R_PTR_SYNC = '0;
  logic [AW-1:0] W_ADDR;
  logic          W_CLKEN;
  logic [PW-1:0] W_PTR;
  logic          W_FULL;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic          W_ALMOST_FULL;
`endif

`ifdef FIFO_WR_ALMOST_FULL_EN
  fifo_wr_ptr_full #(.ADDR_WIDTH(AW), .AF_LEVEL(6)) dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .R_PTR_SYNC(R_PTR_SYNC),
    .W_ADDR(W_ADDR), .W_CLKEN(W_CLKEN), .W_PTR(W_PTR), .W_FULL(W_FULL),
    .W_ALMOST_FULL(W_ALMOST_FULL)
  );
`else
  fifo_wr_ptr_full #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .R_PTR_SYNC(R_PTR_SYNC),
    .W_ADDR(W_ADDR), .W_CLKEN(W_CLKEN), .W_PTR(W_PTR), .W_FULL(W_FULL)
  );
`endif

  always #5 CLK = ~CLK;

  // Inputs for one cycle plus the outputs expected during that same cycle (before its edge).
  typedef struct {
    int            idx;
    logic          rst;
    logic          inc;
    logic [PW-1:0] r;
    logic [AW-1:0] addr;
    logic          clken;
    logic [PW-1:0] ptr;
    logic          full;
    logic          af;
  } vec_t;

  vec_t table_q[$];
  vec_t exp_q[$];
  vec_t mv;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic inc, input logic [PW-1:0] r,
                     input logic [AW-1:0] addr, input logic clken,
                     input logic [PW-1:0] ptr, input logic full, input logic af);
    vec_t v;
    v.idx = table_q.size();
    v.rst = rst; v.inc = inc; v.r = r;
    v.addr = addr; v.clken = clken; v.ptr = ptr; v.full = full; v.af = af;
    table_q.push_back(v);
  endtask

  function automatic void check(input int idx, input string name, input int got, input int want);
    if (got != want) begin
      $display("FAIL vec%0d %s: got %0d, want %0d", idx, name, got, want);
      n_err++;
    end
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mv = exp_q.pop_front();
      n_vec++;
      $display("vec %0d: RST=%b W_INC=%b R_PTR_SYNC=%b -> W_ADDR=%0d W_CLKEN=%b W_PTR=%b W_FULL=%b",
               mv.idx, mv.rst, mv.inc, mv.r, W_ADDR, W_CLKEN, W_PTR, W_FULL);
      check(mv.idx, "W_ADDR",  int'(W_ADDR),  int'(mv.addr));
      check(mv.idx, "W_CLKEN", int'(W_CLKEN), int'(mv.clken));
      check(mv.idx, "W_PTR",   int'(W_PTR),   int'(mv.ptr));
      check(mv.idx, "W_FULL",  int'(W_FULL),  int'(mv.full));
`ifdef FIFO_WR_ALMOST_FULL_EN
      check(mv.idx, "W_ALMOST_FULL", int'(W_ALMOST_FULL), int'(mv.af));
`endif
    end
  end

  initial begin
    //  rst inc r        addr clk ptr      full af
    // Reset held, write request ignored
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // Three writes, then reset pulled mid-cycle
    add(1, 1, 4'b0000, 0, 1, 4'b0000, 0, 0);
    add(1, 1, 4'b0000, 1, 1, 4'b0001, 0, 0);
    add(1, 1, 4'b0000, 2, 1, 4'b0011, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // Eight writes from empty, R_PTR_SYNC = 0
    add(1, 1, 4'b0000, 0, 1, 4'b0000, 0, 0);
    add(1, 1, 4'b0000, 1, 1, 4'b0001, 0, 0);
    add(1, 1, 4'b0000, 2, 1, 4'b0011, 0, 0);
    add(1, 1, 4'b0000, 3, 1, 4'b0010, 0, 0);
    add(1, 1, 4'b0000, 4, 1, 4'b0110, 0, 0);
    add(1, 1, 4'b0000, 5, 1, 4'b0111, 0, 0);
    add(1, 1, 4'b0000, 6, 1, 4'b0101, 0, 1);
    add(1, 1, 4'b0000, 7, 1, 4'b0100, 0, 1);
    // Writes while full are dropped
    add(1, 1, 4'b0000, 0, 0, 4'b1100, 1, 1);
    add(1, 1, 4'b0000, 0, 0, 4'b1100, 1, 1);
    add(1, 1, 4'b0000, 0, 0, 4'b1100, 1, 1);
    // One read seen, full drops, next write refills
    add(1, 0, 4'b0001, 0, 0, 4'b1100, 1, 1);
    add(1, 1, 4'b0001, 0, 1, 4'b1100, 0, 1);
    add(1, 0, 4'b0001, 1, 0, 4'b1101, 1, 1);
    // Read pointer moves to level 5
    add(1, 0, 4'b0110, 1, 0, 4'b1101, 1, 1);
    add(1, 0, 4'b0110, 1, 0, 4'b1101, 0, 0);
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // 20 writes, read pointer trailing by two cycles
    add(1, 1, 4'b0000, 0, 1, 4'b0000, 0, 0);
    add(1, 1, 4'b0000, 1, 1, 4'b0001, 0, 0);
    add(1, 1, 4'b0000, 2, 1, 4'b0011, 0, 0);
    add(1, 1, 4'b0001, 3, 1, 4'b0010, 0, 0);
    add(1, 1, 4'b0011, 4, 1, 4'b0110, 0, 0);
    add(1, 1, 4'b0010, 5, 1, 4'b0111, 0, 0);
    add(1, 1, 4'b0110, 6, 1, 4'b0101, 0, 0);
    add(1, 1, 4'b0111, 7, 1, 4'b0100, 0, 0);
    add(1, 1, 4'b0101, 0, 1, 4'b1100, 0, 0);
    add(1, 1, 4'b0100, 1, 1, 4'b1101, 0, 0);
    add(1, 1, 4'b1100, 2, 1, 4'b1111, 0, 0);
    add(1, 1, 4'b1101, 3, 1, 4'b1110, 0, 0);
    add(1, 1, 4'b1111, 4, 1, 4'b1010, 0, 0);
    add(1, 1, 4'b1110, 5, 1, 4'b1011, 0, 0);
    add(1, 1, 4'b1010, 6, 1, 4'b1001, 0, 0);
    add(1, 1, 4'b1011, 7, 1, 4'b1000, 0, 0);
    add(1, 1, 4'b1001, 0, 1, 4'b0000, 0, 0);
    add(1, 1, 4'b1000, 1, 1, 4'b0001, 0, 0);
    add(1, 1, 4'b0000, 2, 1, 4'b0011, 0, 0);
    add(1, 1, 4'b0001, 3, 1, 4'b0010, 0, 0);
    add(1, 0, 4'b0011, 4, 0, 4'b0110, 0, 0);

    #1 RST = 1'b0;
    foreach (table_q[i]) begin
      @(posedge CLK);
      #1;
      RST        = table_q[i].rst;
      W_INC      = table_q[i].inc;
      R_PTR_SYNC = table_q[i].r;
      exp_q.push_back(table_q[i]);
    end

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge CLK);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
